// File: rtl/tst_dout_chk_prbs31.sv
// -----------------------------------------------------------------------------
// tst_dout_chk_prbs31
//
// Receive-side checker for a 28-bit/cycle PRBS31 stream (x^31 + x^28 + 1,
// 28 LFSR steps per word, word = state[30:3]). It seeds its own LFSR from two
// received words, verifies LOCK_CNT further words, and then free-runs in
// lockstep with the stream. It reports lock, per-word error pulses and
// saturating bit/word/checked-word counters.
//
// Optional feature macro: TST_DOUT_CHK_PRBS31_ERRCAP_EN
//   When defined, the expected word, the received word and the word index of
//   the first locked mismatch are captured. When undefined, the cap_* outputs
//   are tied to zero.
//
// Parameters:
//   LOCK_CNT    consecutive good words in verify before lock
//   UNLOCK_CNT  consecutive bad words while locked that drop lock
//   CNT_W       width of all counters
//
// Ports:
//   clk            in   clock
//   arstn          in   asynchronous reset, active low
//   vld_i          in   dat_i valid
//   dat_i          in   received PRBS word (28 bits)
//   clr_i          in   synchronous clear of counters and capture registers
//   lock_o         out  high while locked
//   err_o          out  one-cycle pulse per mismatching locked word
//   err_bit_cnt_o  out  errored bits while locked (saturating)
//   err_wrd_cnt_o  out  errored words while locked (saturating)
//   wrd_cnt_o      out  words checked while locked (saturating)
//   cap_vld_o      out  first-error capture valid
//   cap_exp_o      out  expected word at first error
//   cap_rcv_o      out  received word at first error
//   cap_idx_o      out  word count at first error
//
// Pipeline: stage 0 registers the input, stage 1 compares and runs the FSM,
// stage 2 popcounts and updates counters/outputs (3 clk from vld_i).
// -----------------------------------------------------------------------------
module tst_dout_chk_prbs31 #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             vld_i,
  input  logic [27:0]      dat_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_bit_cnt_o,
  output logic [CNT_W-1:0] err_wrd_cnt_o,
  output logic [CNT_W-1:0] wrd_cnt_o,
  output logic             cap_vld_o,
  output logic [27:0]      cap_exp_o,
  output logic [27:0]      cap_rcv_o,
  output logic [CNT_W-1:0] cap_idx_o
);

  localparam int unsigned GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int unsigned BAD_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;
  localparam int unsigned SUM_W  = CNT_W + 6;

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] S_ACQ0 = 2'd0;
  localparam logic [1:0] S_ACQ1 = 2'd1;
  localparam logic [1:0] S_VFY  = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  // 28-step jump of the x^31 + x^28 + 1 LFSR
  function automatic logic [30:0] f_nxt(input logic [30:0] s);
    logic [30:0] n;
    n[2:0] = s[30:28];
    for (int k = 3; k <= 30; k++) begin
      n[k] = s[k-3] ^ s[k];
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 0: input register
  // ---------------------------------------------------------------------------
  logic        r_vld0;
  logic [27:0] r_dat0;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_vld0 <= 1'b0;
      r_dat0 <= '0;
    end else begin
      r_vld0 <= vld_i;
      r_dat0 <= dat_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: compare and acquisition FSM
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state, w_state_d;
  logic [30:0]       r_s, w_s_d;
  logic [2:0]        r_w0_top, w_w0_top_d;  // only w0[27:25] is needed for seeding
  logic [GOOD_W-1:0] r_good, w_good_d;
  logic [BAD_W-1:0]  r_bad, w_bad_d;

  logic [30:0] w_nxt;
  logic [27:0] w_exp;
  logic [27:0] w_xor;
  logic        w_mis;

  assign w_nxt = f_nxt(r_s);
  assign w_exp = w_nxt[30:3];
  assign w_xor = r_dat0 ^ w_exp;
  assign w_mis = |w_xor;

  always_comb begin
    w_state_d  = r_state;
    w_s_d      = r_s;
    w_w0_top_d = r_w0_top;
    w_good_d   = r_good;
    w_bad_d    = r_bad;
    if (r_vld0) begin
      case (r_state)
        S_ACQ0: begin
          w_w0_top_d = r_dat0[27:25];
          w_state_d  = S_ACQ1;
        end
        S_ACQ1: begin
          // The seed's low bits are the top bits of the previous state
          w_s_d     = {r_dat0, r_w0_top};
          w_good_d  = '0;
          w_state_d = S_VFY;
        end
        S_VFY: begin
          w_s_d = w_nxt;
          if (w_mis) begin
            // Discarded: the next word starts a fresh acquisition
            w_state_d = S_ACQ0;
          end else if (r_good == GOOD_LAST) begin
            w_bad_d   = '0;
            w_state_d = S_LOCK;
          end else begin
            w_good_d = r_good + 1'b1;
          end
        end
        default: begin  // S_LOCK: flywheel, never reseeded from data
          w_s_d = w_nxt;
          if (!w_mis) begin
            w_bad_d = '0;
          end else if (r_bad == BAD_LAST) begin
            w_state_d = S_ACQ0;
          end else begin
            w_bad_d = r_bad + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state  <= S_ACQ0;
      r_s      <= '0;
      r_w0_top <= '0;
      r_good   <= '0;
      r_bad    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_s      <= w_s_d;
      r_w0_top <= w_w0_top_d;
      r_good   <= w_good_d;
      r_bad    <= w_bad_d;
    end
  end

  // Stage 1 result register
  logic        r_chk1;  // word was checked while locked
  logic        r_mis1;
  logic [27:0] r_xor1;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_chk1 <= 1'b0;
      r_mis1 <= 1'b0;
      r_xor1 <= '0;
    end else begin
      r_chk1 <= r_vld0 && (r_state == S_LOCK);
      if (r_vld0) begin
        r_mis1 <= w_mis;
        r_xor1 <= w_xor;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: popcount, counters, outputs
  // ---------------------------------------------------------------------------
  logic             r_lock;
  logic             r_err;
  logic [CNT_W-1:0] r_err_bit_cnt, w_err_bit_cnt_d;
  logic [CNT_W-1:0] r_err_wrd_cnt, w_err_wrd_cnt_d;
  logic [CNT_W-1:0] r_wrd_cnt, w_wrd_cnt_d;

  logic             w_err2;
  logic [4:0]       w_pop;
  logic [SUM_W-1:0] w_bit_sum;

  assign w_err2 = r_chk1 & r_mis1;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 28; i++) begin
      w_pop = w_pop + 5'(r_xor1[i]);
    end
  end

  // Widened add so a 28-bit burst on a narrow counter clamps instead of wrapping
  assign w_bit_sum = {6'b0, r_err_bit_cnt} + {{(CNT_W + 1){1'b0}}, w_pop};

  always_comb begin
    w_wrd_cnt_d     = r_wrd_cnt;
    w_err_wrd_cnt_d = r_err_wrd_cnt;
    w_err_bit_cnt_d = r_err_bit_cnt;
    if (clr_i) begin
      w_wrd_cnt_d     = '0;
      w_err_wrd_cnt_d = '0;
      w_err_bit_cnt_d = '0;
    end else begin
      if (r_chk1 && (r_wrd_cnt != CNT_MAX)) begin
        w_wrd_cnt_d = r_wrd_cnt + 1'b1;
      end
      if (w_err2) begin
        if (r_err_wrd_cnt != CNT_MAX) begin
          w_err_wrd_cnt_d = r_err_wrd_cnt + 1'b1;
        end
        if (|w_bit_sum[SUM_W-1:CNT_W]) begin
          w_err_bit_cnt_d = CNT_MAX;
        end else begin
          w_err_bit_cnt_d = w_bit_sum[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_lock        <= 1'b0;
      r_err         <= 1'b0;
      r_wrd_cnt     <= '0;
      r_err_wrd_cnt <= '0;
      r_err_bit_cnt <= '0;
    end else begin
      r_lock        <= (r_state == S_LOCK);
      r_err         <= w_err2;
      r_wrd_cnt     <= w_wrd_cnt_d;
      r_err_wrd_cnt <= w_err_wrd_cnt_d;
      r_err_bit_cnt <= w_err_bit_cnt_d;
    end
  end

  assign lock_o        = r_lock;
  assign err_o         = r_err;
  assign wrd_cnt_o     = r_wrd_cnt;
  assign err_wrd_cnt_o = r_err_wrd_cnt;
  assign err_bit_cnt_o = r_err_bit_cnt;

  // ---------------------------------------------------------------------------
  // First-error capture
  // ---------------------------------------------------------------------------
`ifdef TST_DOUT_CHK_PRBS31_ERRCAP_EN
  logic [27:0]      r_exp1;
  logic [27:0]      r_rcv1;
  logic             r_cap_vld;
  logic [27:0]      r_cap_exp;
  logic [27:0]      r_cap_rcv;
  logic [CNT_W-1:0] r_cap_idx;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_exp1 <= '0;
      r_rcv1 <= '0;
    end else if (r_vld0) begin
      r_exp1 <= w_exp;
      r_rcv1 <= r_dat0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cap_vld <= 1'b0;
      r_cap_exp <= '0;
      r_cap_rcv <= '0;
      r_cap_idx <= '0;
    end else if (clr_i) begin
      r_cap_vld <= 1'b0;
      r_cap_exp <= '0;
      r_cap_rcv <= '0;
      r_cap_idx <= '0;
    end else if (w_err2 && !r_cap_vld) begin
      // Index is the count of locked words preceding the errored one
      r_cap_vld <= 1'b1;
      r_cap_exp <= r_exp1;
      r_cap_rcv <= r_rcv1;
      r_cap_idx <= r_wrd_cnt;
    end
  end

  assign cap_vld_o = r_cap_vld;
  assign cap_exp_o = r_cap_exp;
  assign cap_rcv_o = r_cap_rcv;
  assign cap_idx_o = r_cap_idx;
`else
  assign cap_vld_o = 1'b0;
  assign cap_exp_o = '0;
  assign cap_rcv_o = '0;
  assign cap_idx_o = '0;
`endif

endmodule

// File: tb/tb_tst_dout_chk_prbs31.sv
module tb_tst_dout_chk_prbs31;

  logic        clk   = 1'b0;
  logic        arstn = 1'b0;
  logic        vld   = 1'b0;
  logic        clr   = 1'b0;
  logic [27:0] dat   = '0;

  // Main instance, default parameters
  logic        lock, err, cap_vld;
  logic [31:0] err_bit, err_wrd, wrd, cap_idx;
  logic [27:0] cap_exp, cap_rcv;

  // Narrow-counter instance that tolerates long error bursts while locked
  logic        lock2, err2, cap_vld2;
  logic [3:0]  err_bit2, err_wrd2, wrd2, cap_idx2;
  logic [27:0] cap_exp2, cap_rcv2;

  int total = 0;
  int bad   = 0;
  int exp_bits;
  logic [30:0] m_s;

  always #5 clk = ~clk;

  tst_dout_chk_prbs31 u_dut (
    .clk(clk), .arstn(arstn), .vld_i(vld), .dat_i(dat), .clr_i(clr),
    .lock_o(lock), .err_o(err), .err_bit_cnt_o(err_bit), .err_wrd_cnt_o(err_wrd),
    .wrd_cnt_o(wrd), .cap_vld_o(cap_vld), .cap_exp_o(cap_exp), .cap_rcv_o(cap_rcv),
    .cap_idx_o(cap_idx)
  );

  tst_dout_chk_prbs31 #(.LOCK_CNT(16), .UNLOCK_CNT(32), .CNT_W(4)) u_sat (
    .clk(clk), .arstn(arstn), .vld_i(vld), .dat_i(dat), .clr_i(clr),
    .lock_o(lock2), .err_o(err2), .err_bit_cnt_o(err_bit2), .err_wrd_cnt_o(err_wrd2),
    .wrd_cnt_o(wrd2), .cap_vld_o(cap_vld2), .cap_exp_o(cap_exp2), .cap_rcv_o(cap_rcv2),
    .cap_idx_o(cap_idx2)
  );

  function automatic logic [30:0] nxt(input logic [30:0] s);
    logic [30:0] n;
    n[2:0] = s[30:28];
    for (int k = 3; k <= 30; k++) n[k] = s[k-3] ^ s[k];
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic cyc(input logic v, input logic [27:0] d);
    vld = v;
    dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic prbs();
    cyc(1'b1, m_s[30:3]);
    m_s = nxt(m_s);
  endtask

  task automatic prbs_x(input logic [27:0] x);
    cyc(1'b1, m_s[30:3] ^ x);
    m_s = nxt(m_s);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 28'($urandom));
  endtask

  task automatic gap_prbs();
    idle(int'($urandom_range(0, 2)));
    prbs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_s = 31'h09abcdef;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", lock, 0);
    chk("rst_err", err, 0);
    chk("rst_wrd", wrd, 0);
    chk("rst_err_wrd", err_wrd, 0);
    chk("rst_err_bit", err_bit, 0);
    chk("rst_cap_vld", cap_vld, 0);
    arstn = 1'b1;

    // 1: acquisition from the reference seed; word 17 locks, visible 3 clk later
    repeat (19) prbs();
    chk("t1_lock_early", lock, 0);
    prbs();
    chk("t1_lock", lock, 1);
    chk("t1_lock2", lock2, 1);
    repeat (10) prbs();                       // call 30: locked words 18..27 counted
    chk("t1_wrd", wrd, 10);
    chk("t1_err_wrd", err_wrd, 0);
    chk("t1_err_bit", err_bit, 0);
    chk("t1_err", err, 0);

    // 2: single word with bits 0 and 27 flipped
    prbs_x(28'h8000001);                      // call 31
    prbs();
    chk("t2_err_before", err, 0);
    prbs();                                   // call 33
    chk("t2_err_pulse", err, 1);
    chk("t2_err_wrd", err_wrd, 1);
    chk("t2_err_bit", err_bit, 2);
    chk("t2_wrd", wrd, 13);
`ifdef TST_DOUT_CHK_PRBS31_ERRCAP_EN
    chk("t2_cap_vld", cap_vld, 1);
    chk("t2_cap_xor", cap_exp ^ cap_rcv, 28'h8000001);
`else
    chk("t2_cap_vld", cap_vld, 0);
    chk("t2_cap_exp", cap_exp, 0);
`endif
    prbs();
    chk("t2_err_after", err, 0);
    chk("t2_lock_held", lock, 1);

    // 3: four all-zero words drop lock
    exp_bits = 2;
    repeat (4) begin
      exp_bits += $countones(m_s[30:3]);
      cyc(1'b1, 28'h0);
      m_s = nxt(m_s);
    end                                       // calls 35..38
    prbs();
    chk("t3_lock_still", lock, 1);
    prbs();                                   // call 40
    chk("t3_unlock", lock, 0);
    chk("t3_err_wrd", err_wrd, 5);
    chk("t3_err_bit", err_bit, 64'(exp_bits));
    chk("t3_wrd", wrd, 20);
    repeat (16) prbs();                       // call 56: last verify word
    prbs();
    chk("t3_relock_early", lock, 0);
    prbs();
    chk("t3_relock", lock, 1);
    chk("t3_keep_err_wrd", err_wrd, 5);
    chk("t3_keep_wrd", wrd, 20);
    chk("t3_keep_err_bit", err_bit, 64'(exp_bits));

    // 6: reset while locked
    arstn = 1'b0;
    #2;
    chk("t6_lock", lock, 0);
    chk("t6_lock2", lock2, 0);
    chk("t6_err_wrd", err_wrd, 0);
    chk("t6_err_bit", err_bit, 0);
    chk("t6_wrd", wrd, 0);
    idle(2);
    arstn = 1'b1;

    // 4: acquisition with random valid gaps
    repeat (17) gap_prbs();
    idle(4);
    chk("t4_no_lock", lock, 0);
    gap_prbs();
    idle(3);
    chk("t4_lock", lock, 1);
    repeat (20) gap_prbs();
    idle(3);
    chk("t4_wrd", wrd, 20);
    chk("t4_err_wrd", err_wrd, 0);
    chk("t4_err_bit", err_bit, 0);
    chk("t4_lock_held", lock, 1);

    // 4b: corrupted second acquisition word costs three extra words
    arstn = 1'b0;
    idle(1);
    arstn = 1'b1;
    prbs();
    prbs_x(28'h8000000);
    repeat (18) prbs();
    idle(3);
    chk("t4b_no_lock", lock, 0);
    prbs();
    idle(3);
    chk("t4b_lock", lock, 1);
    chk("t4b_wrd", wrd, 0);

    // 5: saturation on the 4-bit instance
    chk("t5_lock2", lock2, 1);
    clr = 1'b1;
    prbs();
    clr = 1'b0;
    chk("t5_clr_wrd", err_wrd2, 0);
    chk("t5_clr_bit", err_bit2, 0);
    repeat (3) prbs_x(28'hFFFFFFF);
    chk("t5_bit_sat1", err_bit2, 15);
    chk("t5_wrd_one", err_wrd2, 1);
    repeat (19) prbs_x(28'hFFFFFFF);          // 22 errored words sent, 20 counted
    chk("t5_wrd_sat", err_wrd2, 15);
    chk("t5_bit_sat", err_bit2, 15);
    clr = 1'b1;
    prbs_x(28'hFFFFFFF);                      // clear collides with an error update
    clr = 1'b0;
    chk("t5_clr_coinc_wrd", err_wrd2, 0);
    chk("t5_clr_coinc_bit", err_bit2, 0);
    prbs();
    chk("t5_after_clr_wrd", err_wrd2, 1);
    chk("t5_after_clr_bit", err_bit2, 15);
    chk("t5_lock2_held", lock2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
